// File: rtl/periph_resp_mux_pkg.sv
// periph_resp_mux_pkg
// Shared bus definitions for the peripheral response mux: FSM state encoding,
// target select indices and default parameters.
package periph_resp_mux_pkg;

  localparam int XLEN_DEF           = 32;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // Select vector layout is {gpio0, uart0, data_mem}.
  localparam int NUM_TGT   = 3;
  localparam int SEL_DMEM  = 0;
  localparam int SEL_UART0 = 1;
  localparam int SEL_GPIO0 = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2,
    ST_RESP = 2'd3
  } bus_state_e;

  // Exactly one bit set.
  function automatic logic sel_onehot(input logic [NUM_TGT-1:0] sel);
    return (sel != '0) && ((sel & (sel - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/periph_resp_mux_bus_timeout_cnt.sv
// bus_timeout_cnt
// Counts completed WAIT cycles of the current access and flags the last
// allowed WAIT cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   clear      : reload count to 0 (request acceptance)
//   enable     : FSM is in WAIT; count this cycle
//   expired    : current WAIT cycle is cycle number TIMEOUT_CYCLES
module bus_timeout_cnt
  import periph_resp_mux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_cnt;

  // Saturating up-counter: never wraps back into a live window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && (r_cnt != 8'hFF)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  // r_cnt holds the number of WAIT cycles already finished, so the
  // TIMEOUT_CYCLES-th WAIT cycle sees r_cnt == TIMEOUT_CYCLES-1.
  assign expired = enable && (r_cnt >= LP_LAST);

endmodule

// File: rtl/periph_resp_mux.sv
// periph_resp_mux
// Routes a single core access to one of three targets (data_mem, uart0,
// gpio0), waits for that target's ack or a timeout, and returns a one-cycle
// response with read data and an error flag.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   req_valid, req_we, req_ready     : core request handshake
//   *_en                             : address-decoder selects
//   *_req                            : single-cycle strobe to the target
//   *_ack, *_rdata                   : target completion and read data
//   resp_valid, resp_rdata, resp_err : response to the core
//
// state | meaning
// IDLE  | ready for a new access
// WAIT  | one target selected, waiting for its ack or timeout
// ERR   | decode error (zero or multiple selects)
// RESP  | one-cycle response pulse
module periph_resp_mux
  import periph_resp_mux_pkg::*;
#(
  parameter int XLEN           = XLEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  input  logic            req_we,
  output logic            req_ready,
  input  logic            data_mem_en,
  input  logic            uart0_addr_en,
  input  logic            gpio0_addr_en,
  output logic            data_mem_req,
  output logic            uart0_req,
  output logic            gpio0_req,
  input  logic            data_mem_ack,
  input  logic            uart0_ack,
  input  logic            gpio0_ack,
  input  logic [XLEN-1:0] data_mem_rdata,
  input  logic [XLEN-1:0] uart0_rdata,
  input  logic [XLEN-1:0] gpio0_rdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  bus_state_e         r_state;
  bus_state_e         w_state_nxt;
  logic [NUM_TGT-1:0] r_sel;
  logic [NUM_TGT-1:0] w_sel_in;
  logic [NUM_TGT-1:0] w_ack_vec;
  logic               r_we;
  logic               r_first;
  logic [XLEN-1:0]    r_resp_rdata;
  logic [XLEN-1:0]    w_resp_rdata_nxt;
  logic               r_resp_err;
  logic               w_resp_err_nxt;
  logic               w_accept;
  logic               w_ack;
  logic               w_expired;
  logic               w_in_wait;
  logic [XLEN-1:0]    w_tgt_rdata;

  assign w_sel_in  = {gpio0_addr_en, uart0_addr_en, data_mem_en};
  assign w_ack_vec = {gpio0_ack, uart0_ack, data_mem_ack};

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_in_wait = (r_state == ST_WAIT);

  // Masking with the registered select drops acks from other targets.
  assign w_ack = |(r_sel & w_ack_vec);

  always_comb begin
    w_tgt_rdata = '0;
    if (r_sel[SEL_DMEM]) begin
      w_tgt_rdata = data_mem_rdata;
    end else if (r_sel[SEL_UART0]) begin
      w_tgt_rdata = uart0_rdata;
    end else if (r_sel[SEL_GPIO0]) begin
      w_tgt_rdata = gpio0_rdata;
    end
  end

  // Strobe only in the first WAIT cycle; ERR never strobes.
  assign data_mem_req = w_in_wait && r_first && r_sel[SEL_DMEM];
  assign uart0_req    = w_in_wait && r_first && r_sel[SEL_UART0];
  assign gpio0_req    = w_in_wait && r_first && r_sel[SEL_GPIO0];

  assign resp_valid = (r_state == ST_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (w_accept),
    .enable (w_in_wait),
    .expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_sel        <= '0;
      r_we         <= 1'b0;
      r_first      <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_first      <= w_accept;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
      if (w_accept) begin
        r_sel <= w_sel_in;
        r_we  <= req_we;
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = sel_onehot(w_sel_in) ? ST_WAIT : ST_ERR;
        end
      end
      ST_WAIT: begin
        // Ack is checked first so it wins over a same-cycle timeout.
        if (w_ack) begin
          w_state_nxt      = ST_RESP;
          w_resp_err_nxt   = 1'b0;
          w_resp_rdata_nxt = r_we ? '0 : w_tgt_rdata;
        end else if (w_expired) begin
          w_state_nxt      = ST_RESP;
          w_resp_err_nxt   = 1'b1;
          w_resp_rdata_nxt = '0;
        end
      end
      ST_ERR: begin
        w_state_nxt      = ST_RESP;
        w_resp_err_nxt   = 1'b1;
        w_resp_rdata_nxt = '0;
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule
